// File: rtl/busy_ctr_pkg.sv
// busy_ctr_pkg: shared types and helpers for the
// multi-channel busy countdown block.
package busy_ctr_pkg;

    localparam int CTR_WIDTH_DEF = 16;

    typedef logic [CTR_WIDTH_DEF-1:0] ctr_t;

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/busy_ctr_chan.sv
// busy_ctr_chan: one countdown channel with load,
// abort, pause-aware decrement and a done pulse.
module busy_ctr_chan
    import busy_ctr_pkg::*;
#(
    parameter int CTR_WIDTH  = CTR_WIDTH_DEF,
    parameter int MAX_AMOUNT = 22
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 load,
    input  logic [CTR_WIDTH-1:0] amount,
    input  logic                 abort,
    input  logic                 pause,
    output logic                 busy,
    output logic                 done
);

    logic [CTR_WIDTH-1:0] cnt;
    logic                 last;

    assign busy = (cnt != '0);
    assign last = (cnt == CTR_WIDTH'(1));

    // Load only reaches an idle channel, so it never races abort.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= amount;
        end else if (busy && abort) begin
            cnt <= '0;
        end else if (busy && !pause) begin
            cnt <= cnt - CTR_WIDTH'(1);
        end
    end

    // Pulse only on a natural 1 -> 0 step, never abort/reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            done <= 1'b0;
        end else begin
            done <= last && !abort && !pause;
        end
    end

`ifdef FORMAL
    // Loads are range-checked upstream; count never exceeds max.
    always @(posedge CLK) begin
        if (!RST) begin
            assert (cnt <= CTR_WIDTH'(MAX_AMOUNT));
        end
    end
`endif

endmodule

// File: rtl/multi_busy_ctr.sv
// multi_busy_ctr: start decode, ready mux, sticky error
// and busy reduction around NUM_CH countdown channels.
module multi_busy_ctr
    import busy_ctr_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int CTR_WIDTH  = CTR_WIDTH_DEF,
    parameter int MAX_AMOUNT = 22
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      start__ENA,
    input  logic [ch_w(NUM_CH)-1:0]   start_ch,
    input  logic [CTR_WIDTH-1:0]      start_amount,
    output logic                      start__RDY,
    input  logic [NUM_CH-1:0]         abort__ENA,
    input  logic                      pause,
    output logic [NUM_CH-1:0]         busy,
    output logic [NUM_CH-1:0]         done,
    output logic                      any_busy,
    output logic                      err
);

    localparam int CH_W = ch_w(NUM_CH);
    localparam logic [CTR_WIDTH-1:0] MAX_C =
        CTR_WIDTH'(MAX_AMOUNT);

    logic              legal;
    logic              accept;
    logic [NUM_CH-1:0] load;

    assign legal  = (start_amount != '0) &&
                    (start_amount <= MAX_C);
    assign accept = start__ENA && start__RDY;

    // Ready follows the selected channel; unmapped index is busy.
    always_comb begin
        start__RDY = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (start_ch == CH_W'(i)) begin
                start__RDY = !busy[i];
            end
        end
    end

    // Sticky flag for an accepted start with a bad amount.
    always_ff @(posedge CLK) begin
        if (RST) begin
            err <= 1'b0;
        end else if (accept && !legal) begin
            err <= 1'b1;
        end
    end

    assign any_busy = |busy;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign load[i] = accept && legal &&
                         (start_ch == CH_W'(i));

        busy_ctr_chan #(
            .CTR_WIDTH (CTR_WIDTH),
            .MAX_AMOUNT(MAX_AMOUNT)
        ) u_chan (
            .CLK   (CLK),
            .RST   (RST),
            .load  (load[i]),
            .amount(start_amount),
            .abort (abort__ENA[i]),
            .pause (pause),
            .busy  (busy[i]),
            .done  (done[i])
        );
    end

endmodule

// File: tb/tb_multi_busy_ctr.sv
// tb_multi_busy_ctr: directed scenarios plus random
// traffic checked against a remaining-cycles model.
module tb_multi_busy_ctr;

    localparam int NUM_CH = 4;
    localparam int CW     = 16;
    localparam int MAXA   = 22;

    logic              CLK = 1'b0;
    logic              RST;
    logic              start__ENA;
    logic [1:0]        start_ch;
    logic [CW-1:0]     start_amount;
    logic              start__RDY;
    logic [NUM_CH-1:0] abort__ENA;
    logic              pause;
    logic [NUM_CH-1:0] busy;
    logic [NUM_CH-1:0] done;
    logic              any_busy;
    logic              err;

    multi_busy_ctr #(
        .NUM_CH    (NUM_CH),
        .CTR_WIDTH (CW),
        .MAX_AMOUNT(MAXA)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .start__ENA  (start__ENA),
        .start_ch    (start_ch),
        .start_amount(start_amount),
        .start__RDY  (start__RDY),
        .abort__ENA  (abort__ENA),
        .pause       (pause),
        .busy        (busy),
        .done        (done),
        .any_busy    (any_busy),
        .err         (err)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    int                rem [NUM_CH];
    logic [NUM_CH-1:0] done_m;
    logic              err_m;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic bit rdy_m();
        if (int'(start_ch) >= NUM_CH) return 1'b0;
        return rem[start_ch] == 0;
    endfunction

    task automatic compare();
        logic [NUM_CH-1:0] bm;
        for (int i = 0; i < NUM_CH; i++) bm[i] = (rem[i] != 0);
        chk("busy", 32'(busy), 32'(bm));
        chk("done", 32'(done), 32'(done_m));
        chk("any_busy", 32'(any_busy), 32'(|bm));
        chk("err", 32'(err), 32'(err_m));
        chk("start_rdy", 32'(start__RDY), 32'(rdy_m()));
    endtask

    task automatic tick();
        int                nrem [NUM_CH];
        logic [NUM_CH-1:0] nd;
        logic              ne;
        int                amt;
        nd  = '0;
        ne  = err_m;
        amt = int'(start_amount);
        if (RST) begin
            for (int i = 0; i < NUM_CH; i++) nrem[i] = 0;
            ne = 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                nrem[i] = rem[i];
                if (rem[i] > 0) begin
                    if (abort__ENA[i]) begin
                        nrem[i] = 0;
                    end else if (!pause) begin
                        nrem[i] = rem[i] - 1;
                        nd[i]   = (rem[i] == 1);
                    end
                end
            end
            if (start__ENA && rdy_m()) begin
                if (amt >= 1 && amt <= MAXA)
                    nrem[start_ch] = amt;
                else
                    ne = 1'b1;
            end
        end
        @(posedge CLK);
        for (int i = 0; i < NUM_CH; i++) rem[i] = nrem[i];
        done_m = nd;
        err_m  = ne;
        @(negedge CLK);
        if (chk_en) compare();
    endtask

    task automatic idle();
        start__ENA = 1'b0;
        abort__ENA = '0;
        pause      = 1'b0;
        RST        = 1'b0;
    endtask

    task automatic start(input int ch, input int amt);
        start__ENA   = 1'b1;
        start_ch     = 2'(ch);
        start_amount = CW'(amt);
        tick();
        start__ENA   = 1'b0;
    endtask

    initial begin
        int bcnt, dcnt, dat;
        bit b3, b4;
        for (int i = 0; i < NUM_CH; i++) rem[i] = 0;
        done_m = '0;
        err_m  = 1'b0;
        idle();
        start_ch     = '0;
        start_amount = '0;
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        chk_en = 1;
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_any", 32'(any_busy), 32'h0);

        // ch0, 22 cycles; late start at the last cycle ignored
        start(0, 22);
        bcnt = 0; dcnt = 0; dat = 0;
        for (int k = 1; k <= 30; k++) begin
            if (busy[0]) bcnt++;
            if (done[0]) begin dcnt++; dat = k; end
            start__ENA   = (k == 22);
            start_ch     = 2'd0;
            start_amount = CW'(5);
            tick();
        end
        start__ENA = 1'b0;
        #1;
        chk("a_busy_cycles", 32'(bcnt), 32'd22);
        chk("a_done_count", 32'(dcnt), 32'd1);
        chk("a_done_cycle", 32'(dat), 32'd23);
        chk("a_rdy_after", 32'(start__RDY), 32'd1);

        // ch1, 5 cycles with pause in cycles 2..4
        start(1, 5);
        bcnt = 0; dcnt = 0;
        for (int k = 1; k <= 14; k++) begin
            if (busy[1]) bcnt++;
            if (done[1]) dcnt++;
            pause = (k >= 2 && k <= 4);
            tick();
        end
        pause = 1'b0;
        chk("b_busy_cycles", 32'(bcnt), 32'd8);
        chk("b_done_count", 32'(dcnt), 32'd1);

        // ch2, 10 cycles aborted in cycle 3
        start(2, 10);
        dcnt = 0; b3 = 0; b4 = 1;
        for (int k = 1; k <= 14; k++) begin
            if (k == 3) b3 = busy[2];
            if (k == 4) b4 = busy[2];
            if (done[2]) dcnt++;
            abort__ENA = (k == 3) ? 4'b0100 : 4'b0000;
            tick();
        end
        abort__ENA = '0;
        chk("c_busy_c3", 32'(b3), 32'd1);
        chk("c_busy_c4", 32'(b4), 32'd0);
        chk("c_no_done", 32'(dcnt), 32'd0);

        // ch0 busy: bad start on ch0 ignored, then ch1 gets 3
        start(0, 10);
        start(0, 0);
        start(1, 3);
        chk("e_ch0_busy", 32'(busy[0]), 32'd1);
        chk("e_err_clean", 32'(err), 32'd0);
        bcnt = 0;
        for (int k = 1; k <= 10; k++) begin
            if (busy[1]) bcnt++;
            tick();
        end
        chk("e_ch1_cycles", 32'(bcnt), 32'd3);
        for (int k = 0; k < 10; k++) tick();

        // ch3 illegal amounts: no load, sticky err
        start(3, 0);
        chk("d_err_zero", 32'(err), 32'd1);
        chk("d_busy_zero", 32'(busy[3]), 32'd0);
        start(3, 23);
        chk("d_busy_23", 32'(busy[3]), 32'd0);
        for (int k = 0; k < 5; k++) tick();
        chk("d_err_sticky", 32'(err), 32'd1);

        // reset with all four channels busy
        for (int c = 0; c < NUM_CH; c++) start(c, 20);
        chk("f_all_busy", 32'(busy), 32'hf);
        RST = 1'b1;
        start(0, 7);
        RST = 1'b0;
        chk("f_busy", 32'(busy), 32'h0);
        chk("f_err", 32'(err), 32'h0);
        dcnt = 0;
        for (int k = 0; k < 25; k++) begin
            if (done != 0) dcnt++;
            tick();
        end
        chk("f_no_done", 32'(dcnt), 32'd0);

        // random traffic against the model
        for (int n = 0; n < 4000; n++) begin
            int r;
            RST        = ($urandom_range(0, 299) == 0);
            start__ENA = $urandom_range(0, 1) == 1;
            start_ch   = 2'($urandom_range(0, 3));
            r = $urandom_range(0, 99);
            if (r < 2)
                start_amount = '0;
            else if (r < 4)
                start_amount = CW'($urandom_range(23, 65535));
            else
                start_amount = CW'($urandom_range(1, MAXA));
            for (int i = 0; i < NUM_CH; i++)
                abort__ENA[i] = ($urandom_range(0, 15) == 0);
            pause = ($urandom_range(0, 7) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
